// File: rtl/pc_seq_ctrl.sv
// Fetch/execute sequencer owning the architectural PC; fetches at pc, holds the word for the EXU, commits pc+4 or a branch target.
// At least 3 cycles per instruction (FETCH->WAIT->EXEC); the fetch request is held until ifu_req_ready, and all outputs are registered.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  input  logic        ifu_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        exu_done,
  input  logic        pc_sel,
  input  logic [31:0] alu_target,
  input  logic        halt_req,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retire_pc;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic        r_retire;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] w_next_pc;
  logic        w_next_misaligned;

  // Candidate successor PC; the adder wraps naturally at 2^32.
  assign w_next_pc         = pc_sel ? alu_target : (r_pc + 32'd4);
  assign w_next_misaligned = |w_next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_retire_pc  <= 32'd0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_retire     <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state     <= S_FETCH;
          r_req_valid <= 1'b1;
        end
        S_FETCH: begin
          // A response arriving with the accept is deliberately not looked at here.
          if (ifu_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_inst       <= ifu_rsp_inst;
              r_inst_valid <= 1'b1;
              r_state      <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (exu_done) begin
            r_inst_valid <= 1'b0;
            if (halt_req) begin
              r_retire    <= 1'b1;
              r_retire_pc <= r_pc;
              r_halted    <= 1'b1;
              r_state     <= S_HALT;
            end else if (w_next_misaligned) begin
              // Bad target: stop without committing, pc keeps the faulting instruction.
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pc        <= w_next_pc;
              r_retire    <= 1'b1;
              r_retire_pc <= r_pc;
              r_req_valid <= 1'b1;
              r_state     <= S_FETCH;
            end
          end
        end
        S_HALT, S_FAULT: begin
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_FAULT;
          r_fault     <= 1'b1;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_req_valid = r_req_valid;
  assign ifu_req_addr  = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign pc            = r_pc;
  assign retire        = r_retire;
  assign retire_pc     = r_retire_pc;
  assign halted        = r_halted;
  assign fault         = r_fault;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Reactive IFU/EXU environment with randomized latencies and ignored-input noise; a scoreboard checks fetches, latched words and retires.
`timescale 1ns/1ps
module tb_pc_seq_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int K_SEQ = 0, K_BR = 1, K_HALT = 2, K_ERR = 3;
  localparam int E_REQ = 0, E_RSP = 1, E_EXEC = 2, E_TERM = 3;

  typedef struct {
    int          kind;
    logic [31:0] tgt;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        exu_done;
  logic        pc_sel;
  logic [31:0] alu_target;
  logic        halt_req;
  logic        retire;
  logic [31:0] retire_pc;
  logic        halted;
  logic        fault;

  pc_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_addr (ifu_req_addr),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_inst (ifu_rsp_inst),
    .ifu_rsp_err  (ifu_rsp_err),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .pc           (pc),
    .exu_done     (exu_done),
    .pc_sel       (pc_sel),
    .alu_target   (alu_target),
    .halt_req     (halt_req),
    .retire       (retire),
    .retire_pc    (retire_pc),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_inst[$];
  logic [31:0] exp_ipc[$];
  logic [31:0] exp_rpc[$];
  logic [31:0] exp_npc[$];
  plan_t       plan[$];

  logic [31:0] model_pc;
  bit          exp_halt, exp_fault, zw, allow_term;
  int          env, n_done, rdy_wait, rsp_wait, exec_wait, max_wait, first_rdy_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  int          cyc = 0;
  int          last_ret = -1;
  logic [31:0] prev_pc = 32'd0;
  logic        prev_rst = 1'b1;
  logic        prev_iv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_ret = -1;
      prev_iv  = 1'b0;
    end else begin
      if (ifu_req_valid) begin
        if (exp_fetch.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_fetch: got request at %h, expected no request", ifu_req_addr);
        end else begin
          check("fetch_addr", ifu_req_addr, exp_fetch[0]);
          if (ifu_req_ready) void'(exp_fetch.pop_front());
        end
      end
      if (inst_valid && !prev_iv) begin
        if (exp_inst.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_inst: got inst_valid with %h, expected none", inst);
        end else begin
          check("inst_latched", inst, exp_inst.pop_front());
          check("exec_pc", pc, exp_ipc.pop_front());
        end
      end
      if (retire) begin
        if (exp_rpc.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_retire: got retire pc %h, expected no retire", retire_pc);
        end else begin
          check("retire_pc", retire_pc, exp_rpc.pop_front());
          check("pc_after_retire", pc, exp_npc.pop_front());
          if (zw && last_ret >= 0) check("retire_period", 32'(cyc - last_ret), 32'd3);
          last_ret = cyc;
        end
      end
      if (!prev_rst && pc !== prev_pc) check_b("pc_moves_only_on_retire", retire, 1'b1);
      prev_iv = inst_valid;
    end
    prev_pc  = pc;
    prev_rst = rst;
  end

  function automatic plan_t mk(input int k, input logic [31:0] t);
    plan_t p;
    p.kind = k;
    p.tgt  = t;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int r;
    r      = int'($urandom_range(0, 99));
    p.kind = K_SEQ;
    p.tgt  = $urandom & 32'hFFFF_FFFC;
    if (r < 35) p.kind = K_BR;
    else if (allow_term && r < 38) p.kind = K_HALT;
    else if (allow_term && r < 41) p.kind = K_ERR;
    else if (allow_term && r < 44) begin
      p.kind = K_BR;
      p.tgt[1:0] = 2'($urandom_range(1, 3));
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = 32'd0;
    exu_done = 1'b0; pc_sel = 1'b0; alu_target = 32'd0; halt_req = 1'b0;
  endtask

  // One cycle of IFU/EXU behaviour; the reference model advances at each completion.
  task automatic drive();
    plan_t       p;
    logic [31:0] nxt;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = $urandom;
    exu_done = 1'b0; pc_sel = 1'($urandom_range(0, 1)); alu_target = $urandom;
    halt_req = 1'($urandom_range(0, 1));
    case (env)
      E_REQ: begin
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_err   = 1'($urandom_range(0, 1));
        exu_done      = 1'($urandom_range(0, 1));
        if (ifu_req_valid) begin
          if (rdy_wait == 0) begin
            ifu_req_ready = 1'b1;
            env           = E_RSP;
            rsp_wait      = int'($urandom_range(0, max_wait));
          end else rdy_wait--;
        end
      end
      E_RSP: begin
        exu_done = 1'($urandom_range(0, 1));
        if (rsp_wait == 0) begin
          if (plan.size() == 0) plan.push_back(rand_plan());
          ifu_rsp_valid = 1'b1;
          if (plan[0].kind == K_ERR) begin
            void'(plan.pop_front());
            ifu_rsp_err = 1'b1;
            exp_fault   = 1'b1;
            env         = E_TERM;
          end else begin
            exp_inst.push_back(ifu_rsp_inst);
            exp_ipc.push_back(model_pc);
            env       = E_EXEC;
            exec_wait = int'($urandom_range(0, max_wait));
          end
        end else rsp_wait--;
      end
      E_EXEC: begin
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_err   = 1'($urandom_range(0, 1));
        halt_req      = 1'b0;
        if (exec_wait == 0) begin
          p        = plan.pop_front();
          exu_done = 1'b1;
          halt_req = (p.kind == K_HALT);
          pc_sel   = (p.kind == K_BR);
          if (p.kind == K_BR) alu_target = p.tgt;
          if (p.kind == K_HALT) begin
            exp_rpc.push_back(model_pc);
            exp_npc.push_back(model_pc);
            exp_halt = 1'b1;
            env      = E_TERM;
          end else begin
            nxt = (p.kind == K_BR) ? p.tgt : model_pc + 32'd4;
            if (nxt[1:0] != 2'b00) begin
              exp_fault = 1'b1;
              env       = E_TERM;
            end else begin
              exp_rpc.push_back(model_pc);
              exp_npc.push_back(nxt);
              model_pc = nxt;
              exp_fetch.push_back(nxt);
              n_done++;
              env      = E_REQ;
              rdy_wait = int'($urandom_range(0, max_wait));
            end
          end
        end else exec_wait--;
      end
      default: begin
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_err   = 1'($urandom_range(0, 1));
        exu_done      = 1'($urandom_range(0, 1));
        ifu_req_ready = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_retire_pc", retire_pc, 32'd0);
    check_b("rst_req_valid", ifu_req_valid, 1'b0);
    check_b("rst_inst_valid", inst_valid, 1'b0);
    check_b("rst_retire", retire, 1'b0);
    check_b("rst_halted", halted, 1'b0);
    check_b("rst_fault", fault, 1'b0);
    plan.delete(); exp_fetch.delete(); exp_inst.delete(); exp_ipc.delete();
    exp_rpc.delete(); exp_npc.delete();
    model_pc = RESET_PC;
    exp_fetch.push_back(RESET_PC);
    env = E_REQ; n_done = 0; exp_halt = 1'b0; exp_fault = 1'b0; rdy_wait = first_rdy_wait;
    rst = 1'b0;
    tick();
    check_b("fetch_after_boot", ifu_req_valid, 1'b1);
  endtask

  task automatic run(input int n, input int budget);
    int b;
    b = 0;
    while (n_done < n && env != E_TERM && b < budget) begin
      drive(); tick(); b++;
    end
    if (b >= budget) begin
      checks++; failures++;
      $display("FAIL timeout: got %0d of %0d instructions after %0d cycles", n_done, n, b);
    end
    if (env == E_TERM) begin
      repeat (8) begin drive(); tick(); end
      check_b("term_req_valid", ifu_req_valid, 1'b0);
      check_b("term_inst_valid", inst_valid, 1'b0);
    end else begin
      idle(); tick(); tick();
    end
    check("final_pc", pc, model_pc);
    check_b("halted_flag", halted, exp_halt);
    check_b("fault_flag", fault, exp_fault);
    check("retires_outstanding", 32'(exp_rpc.size()), 32'd0);
    check("insts_outstanding", 32'(exp_inst.size()), 32'd0);
  endtask

  task automatic run_until(input bit in_exec);
    int b;
    b = 0;
    do begin
      drive(); tick(); b++;
    end while (((in_exec && !inst_valid) || (!in_exec && env != E_RSP)) && b < 200);
    if (b >= 200) begin
      checks++; failures++;
      $display("FAIL timeout: got no %s state within %0d cycles", in_exec ? "EXEC" : "WAIT", b);
    end
  endtask

  initial begin
    rst = 1'b1; idle();
    zw = 1'b0; allow_term = 1'b0; max_wait = 0; first_rdy_wait = 0; env = E_TERM;

    // Zero-wait sequential stream: fetches 0,4,8 and a retire every third cycle.
    zw = 1'b1;
    do_reset();
    repeat (3) plan.push_back(mk(K_SEQ, 32'd0));
    run(3, 100);
    zw = 1'b0;

    // Fetch held while ready stays low for four cycles.
    first_rdy_wait = 4; max_wait = 2;
    do_reset();
    repeat (2) plan.push_back(mk(K_SEQ, 32'd0));
    run(2, 200);
    first_rdy_wait = 0;

    // Taken branch from 8000_0010 to 8000_0100.
    do_reset();
    repeat (4) plan.push_back(mk(K_SEQ, 32'd0));
    plan.push_back(mk(K_BR, 32'h8000_0100));
    plan.push_back(mk(K_SEQ, 32'd0));
    run(6, 300);

    // Misaligned target faults without retiring.
    do_reset();
    plan.push_back(mk(K_SEQ, 32'd0));
    plan.push_back(mk(K_BR, 32'h8000_0102));
    run(10, 300);

    // Fetch bus error.
    do_reset();
    plan.push_back(mk(K_SEQ, 32'd0));
    plan.push_back(mk(K_ERR, 32'd0));
    run(10, 300);

    // ebreak halts with a final retire.
    do_reset();
    repeat (2) plan.push_back(mk(K_SEQ, 32'd0));
    plan.push_back(mk(K_HALT, 32'd0));
    run(10, 300);

    // PC wraps from FFFF_FFFC to 0.
    do_reset();
    plan.push_back(mk(K_BR, 32'hFFFF_FFFC));
    repeat (2) plan.push_back(mk(K_SEQ, 32'd0));
    run(3, 300);

    // Reset in EXEC, then in WAIT; fetch must restart from RESET_PC.
    do_reset();
    run(2, 300);
    run_until(1'b1);
    do_reset();
    run(2, 300);
    run_until(1'b0);
    do_reset();
    run(2, 300);

    // Long random stream, then short streams that may end in halt or fault.
    max_wait = 3;
    do_reset();
    run(150, 4000);
    allow_term = 1'b1;
    repeat (6) begin
      do_reset();
      run(40, 1500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
